mem_ctrl: RTL and testbench

Byte-serial memory controller between the CPU core and the 8-bit single-port RAM. It is the responder for the instruction-fetch request issued by the PC stage and for load/store requests from the MEM stage. It converts each 1/2/4-byte request into consecutive RAM byte accesses and returns the assembled little-endian result. It drives `mem_busy`, which the PC stage uses to hold the PC and gate its fetch request.

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: width codes,
// FSM state encoding and the request-width to byte-count helper.
package mem_ctrl_pkg;

  localparam logic [1:0] MemByte = 2'b00;
  localparam logic [1:0] MemHalf = 2'b01;
  localparam logic [1:0] MemWord = 2'b10;

  typedef enum logic [1:0] {
    MemIdle = 2'b00,
    MemBusy = 2'b01,
    MemDone = 2'b10
  } mem_state_e;

  // Index of the last byte of a request; width code 11 is treated as a word.
  function automatic logic [1:0] last_index(input logic [1:0] width);
    logic [1:0] idx;
    case (width)
      MemByte: idx = 2'd0;
      MemHalf: idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves one fetch or load/store at a time,
// splitting it into consecutive 8-bit RAM accesses and assembling the result.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_busy,
  output logic [31:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  if (RAM_LAT != 1) begin : g_lat_check
    $fatal(1, "mem_ctrl: only RAM_LAT = 1 is supported");
  end

  mem_state_e  state_q, state_d;
  logic [1:0]  k_q;
  logic [1:0]  last_q;
  logic        fetch_q;
  logic [23:0] wdata_q;
  logic [23:0] result_q;

  logic        accept;
  logic [31:0] sel_addr;
  logic [1:0]  sel_width;
  logic        sel_we;
  logic        last_byte;
  logic [31:0] full;
  logic [4:0]  res_shift;
  logic [31:0] assembled;

  // Data port wins when both requesters ask in the same IDLE cycle.
  always_comb begin
    accept    = (state_q == MemIdle) && (mem_req || if_req);
    sel_addr  = mem_req ? mem_addr : if_addr;
    sel_width = mem_req ? mem_width : MemWord;
    sel_we    = mem_req && mem_we;
    last_byte = (k_q == last_q);
  end

  // Bytes enter at the top; short requests are right-aligned at completion.
  always_comb begin
    full      = {ram_din, result_q};
    res_shift = {2'd3 - last_q, 3'b000};
    assembled = full >> res_shift;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MemIdle: if (mem_req || if_req) state_d = MemBusy;
      MemBusy: if (last_byte) state_d = MemDone;
      MemDone: state_d = MemIdle;
      default: state_d = MemIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MemIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= 2'd0;
      last_q    <= 2'd0;
      fetch_q   <= 1'b0;
      wdata_q   <= 24'h0;
      result_q  <= 24'h0;
      ram_addr  <= 32'h0;
      ram_dout  <= 8'h0;
      ram_wr    <= 1'b0;
      if_data   <= 32'h0;
      if_done   <= 1'b0;
      mem_rdata <= 32'h0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      unique case (state_q)
        MemIdle: begin
          if (accept) begin
            k_q      <= 2'd0;
            last_q   <= last_index(sel_width);
            fetch_q  <= !mem_req;
            wdata_q  <= mem_wdata[31:8];
            result_q <= 24'h0;
            ram_addr <= sel_addr;
            ram_dout <= mem_wdata[7:0];
            ram_wr   <= sel_we;
          end
        end
        MemBusy: begin
          result_q <= full[31:8];
          if (last_byte) begin
            ram_wr <= 1'b0;
            if (fetch_q) begin
              if_data <= assembled;
              if_done <= 1'b1;
            end else begin
              // Stores complete without disturbing the last load result.
              if (!ram_wr) mem_rdata <= assembled;
              mem_done <= 1'b1;
            end
          end else begin
            k_q      <= k_q + 2'd1;
            ram_addr <= ram_addr + 32'd1;
            ram_dout <= wdata_q[7:0];
            wdata_q  <= {8'h00, wdata_q[23:8]};
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_busy = (state_q != MemIdle);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios with literal results
// plus randomized traffic checked every cycle against a transaction model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_width;
  logic [31:0] if_data, mem_rdata, ram_addr;
  logic        if_done, mem_done, mem_busy, ram_wr;
  logic [7:0]  ram_dout, ram_din;

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_data   (if_data),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_width (mem_width),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .mem_busy  (mem_busy),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din)
  );

  // RAM aliased onto 4 KiB; the model aliases identically.
  bit   [7:0]  ram     [4096];
  bit   [7:0]  exp_mem [4096];
  logic        pk_en = 1'b0;
  logic [11:0] pk_a  = 12'h0;
  logic [7:0]  pk_d  = 8'h0;

  assign ram_din = ram[ram_addr[11:0]];

  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
    else if (pk_en) ram[pk_a] <= pk_d;
  end

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_msg(input string name);
    total++;
    $display("FAIL %s: no accept within cycle budget at %0t", name, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_active = 1'b0;
  int          m_t = 0;
  int          m_n = 0;
  bit          m_we = 1'b0;
  bit          m_fetch = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_res = 32'h0;
  logic [31:0] m_if_data = 32'h0, m_mem_rdata = 32'h0;
  int          acc_mem_cnt = 0, acc_if_cnt = 0;

  function automatic int width_bytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [11:0] byte_idx(input logic [31:0] a, input int k);
    logic [31:0] s;
    s = a + 32'(k);
    return s[11:0];
  endfunction

  function automatic logic [31:0] gather(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = exp_mem[byte_idx(a, i)];
    return r;
  endfunction

  // m_t counts cycles since accept: 1..n present bytes, n+1 is the done cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active    <= 1'b0;
      m_t         <= 0;
      m_if_data   <= 32'h0;
      m_mem_rdata <= 32'h0;
    end else begin
      if (pk_en) exp_mem[pk_a] <= pk_d;
      if (!m_active) begin
        if (mem_req || if_req) begin
          m_active <= 1'b1;
          m_t      <= 1;
          m_fetch  <= !mem_req;
          m_addr   <= mem_req ? mem_addr : if_addr;
          m_n      <= mem_req ? width_bytes(mem_width) : 4;
          m_we     <= mem_req && mem_we;
          m_wdata  <= mem_wdata;
          m_res    <= mem_req ? gather(mem_addr, width_bytes(mem_width)) : gather(if_addr, 4);
          if (mem_req) acc_mem_cnt <= acc_mem_cnt + 1;
          else acc_if_cnt <= acc_if_cnt + 1;
        end
      end else if (m_t <= m_n) begin
        if (m_we) exp_mem[byte_idx(m_addr, m_t - 1)] <= m_wdata[8*(m_t-1) +: 8];
        else if (m_t == m_n) begin
          if (m_fetch) m_if_data <= m_res;
          else m_mem_rdata <= m_res;
        end
        m_t <= m_t + 1;
      end else begin
        m_active <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_busy", 32'(mem_busy), 32'(m_active));
      chk("ram_wr", 32'(ram_wr), 32'(m_active && m_t <= m_n && m_we));
      chk("if_done", 32'(if_done), 32'(m_active && m_t == m_n + 1 && m_fetch));
      chk("mem_done", 32'(mem_done), 32'(m_active && m_t == m_n + 1 && !m_fetch));
      chk("if_data", if_data, m_if_data);
      chk("mem_rdata", mem_rdata, m_mem_rdata);
      if (m_active && m_t <= m_n) begin
        chk("ram_addr", ram_addr, m_addr + 32'(m_t - 1));
        if (m_we) chk("ram_dout", 32'(ram_dout), 32'(m_wdata[8*(m_t-1) +: 8]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pk_a  = a;
    pk_d  = d;
    pk_en = 1'b1;
    step();
    pk_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[11:6] = 6'd0;
    return a;
  endfunction

  // Hold each raised request until the model reports it accepted.
  task automatic wait_accepts();
    int mc0;
    int ic0;
    int budget;
    bit do_rst;
    mc0    = acc_mem_cnt;
    ic0    = acc_if_cnt;
    budget = 0;
    do_rst = ($urandom_range(0, 15) == 0);
    while ((mem_req || if_req) && budget < 40) begin
      step();
      budget++;
      if (mem_req && acc_mem_cnt != mc0) begin
        mem_req   = 1'b0;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end
      if (if_req && acc_if_cnt != ic0) begin
        if_req  = 1'b0;
        if_addr = $urandom;
      end
      if (do_rst && budget == 2) begin
        rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    if (mem_req || if_req) begin
      fail_msg("random_accept");
      mem_req = 1'b0;
      if_req  = 1'b0;
    end
  endtask

  logic [31:0] words    [3];
  logic [31:0] wrap_seq [4];
  int          acc_cyc  [3];

  initial begin
    int ic0;
    int budget;
    int bad;
    int kind;

    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = 32'h0; mem_width = 2'b00; mem_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ram_wr", 32'(ram_wr), 32'h0);
    chk("reset_if_done", 32'(if_done), 32'h0);
    chk("reset_mem_done", 32'(mem_done), 32'h0);
    chk("reset_busy", 32'(mem_busy), 32'h0);
    chk("reset_ram_addr", ram_addr, 32'h0);
    chk("reset_ram_dout", 32'(ram_dout), 32'h0);
    chk("reset_if_data", if_data, 32'h0);
    chk("reset_mem_rdata", mem_rdata, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Word fetch from 0x100.
    poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h10); poke(12'h103, 8'h00);
    if_addr = 32'h100; if_req = 1'b1;
    step();
    if_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fetch_addr", ram_addr, 32'h100 + 32'(i));
      chk("fetch_busy", 32'(mem_busy), 32'h1);
      step();
    end
    chk("fetch_done", 32'(if_done), 32'h1);
    chk("fetch_data", if_data, 32'h00100513);
    chk("fetch_busy5", 32'(mem_busy), 32'h1);
    step();
    chk("fetch_idle", 32'(mem_busy), 32'h0);

    // Simultaneous requests: byte load first, then the fetch.
    poke(12'h200, 8'hFF);
    poke(12'h104, 8'h93); poke(12'h105, 8'h00); poke(12'h106, 8'h10); poke(12'h107, 8'h00);
    mem_addr = 32'h200; mem_we = 1'b0; mem_width = 2'b00; mem_req = 1'b1;
    if_addr = 32'h104; if_req = 1'b1;
    step();
    mem_req = 1'b0;
    chk("prio_addr", ram_addr, 32'h200);
    step();
    chk("prio_mem_done", 32'(mem_done), 32'h1);
    chk("prio_rdata", mem_rdata, 32'h000000FF);
    chk("prio_if_done", 32'(if_done), 32'h0);
    step();
    chk("prio_idle", 32'(mem_busy), 32'h0);
    step();
    chk("prio_fetch_busy", 32'(mem_busy), 32'h1);
    chk("prio_fetch_addr", ram_addr, 32'h104);
    if_req = 1'b0;
    repeat (4) step();
    chk("prio_fetch_done", 32'(if_done), 32'h1);
    chk("prio_fetch_data", if_data, 32'h00100093);
    step();

    // Half store.
    poke(12'h302, 8'h5A);
    mem_addr = 32'h300; mem_we = 1'b1; mem_width = 2'b01; mem_wdata = 32'h1234ABCD; mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    chk("hs_wr0", 32'(ram_wr), 32'h1);
    chk("hs_addr0", ram_addr, 32'h300);
    chk("hs_dout0", 32'(ram_dout), 32'hCD);
    step();
    chk("hs_wr1", 32'(ram_wr), 32'h1);
    chk("hs_addr1", ram_addr, 32'h301);
    chk("hs_dout1", 32'(ram_dout), 32'hAB);
    step();
    chk("hs_wr_off", 32'(ram_wr), 32'h0);
    chk("hs_done", 32'(mem_done), 32'h1);
    step();
    chk("hs_done_pulse", 32'(mem_done), 32'h0);
    chk("hs_ram300", 32'(ram[12'h300]), 32'hCD);
    chk("hs_ram301", 32'(ram[12'h301]), 32'hAB);
    chk("hs_ram302", 32'(ram[12'h302]), 32'h5A);

    // Reset in the middle of a word store.
    poke(12'h300, 8'h00); poke(12'h301, 8'h00); poke(12'h302, 8'h00); poke(12'h303, 8'h00);
    mem_addr = 32'h300; mem_we = 1'b1; mem_width = 2'b10; mem_wdata = 32'h11223344; mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    step();
    step();
    chk("rs_wr_before", 32'(ram_wr), 32'h1);
    rst = 1'b1;
    #1;
    chk("rs_wr_drop", 32'(ram_wr), 32'h0);
    chk("rs_busy", 32'(mem_busy), 32'h0);
    chk("rs_addr", ram_addr, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    step();
    chk("rs_ram300", 32'(ram[12'h300]), 32'h44);
    chk("rs_ram301", 32'(ram[12'h301]), 32'h33);
    chk("rs_ram302", 32'(ram[12'h302]), 32'h00);
    chk("rs_ram303", 32'(ram[12'h303]), 32'h00);
    mem_we = 1'b0;

    // Word load wrapping past the top of the address space.
    wrap_seq[0] = 32'hFFFFFFFE; wrap_seq[1] = 32'hFFFFFFFF;
    wrap_seq[2] = 32'h00000000; wrap_seq[3] = 32'h00000001;
    poke(12'hFFE, 8'h11); poke(12'hFFF, 8'h22); poke(12'h000, 8'h33); poke(12'h001, 8'h44);
    mem_addr = 32'hFFFFFFFE; mem_width = 2'b10; mem_req = 1'b1;
    step();
    mem_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_addr", ram_addr, wrap_seq[i]);
      step();
    end
    chk("wrap_done", 32'(mem_done), 32'h1);
    chk("wrap_data", mem_rdata, 32'h44332211);
    step();

    // Fetch request held high across three consecutive fetches.
    words[0] = 32'h00100093; words[1] = 32'h00200113; words[2] = 32'h00308193;
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < 4; b++) poke(12'(w * 4 + b), words[w][8*b +: 8]);
    if_addr = 32'h0;
    if_req  = 1'b1;
    for (int j = 0; j < 3; j++) begin
      ic0    = acc_if_cnt;
      budget = 0;
      while (acc_if_cnt == ic0 && budget < 20) begin
        step();
        budget++;
      end
      if (acc_if_cnt == ic0) fail_msg("held_accept");
      acc_cyc[j] = cyc;
      if_addr = if_addr + 32'd4;
      if (j == 2) if_req = 1'b0;
      repeat (4) step();
      chk("held_done", 32'(if_done), 32'h1);
      chk("held_data", if_data, words[j]);
    end
    chk("held_period01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    chk("held_period12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
    step();

    // Randomized traffic.
    for (int p = 0; p < 64; p++) poke(12'($urandom_range(0, 67)), 8'($urandom));
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 2);
      if (kind != 1) begin
        if_req  = 1'b1;
        if_addr = rand_addr();
      end
      if (kind != 0) begin
        mem_req   = 1'b1;
        mem_addr  = rand_addr();
        mem_we    = 1'($urandom_range(0, 1));
        mem_width = 2'($urandom_range(0, 3));
        mem_wdata = $urandom;
      end
      wait_accepts();
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (8) step();

    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== exp_mem[i]) bad++;
    chk("ram_image", 32'(bad), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
